// File: rtl/window_sample_packer_pkg.sv
// Shared definitions for the window sample packer and its sibling timer consumers:
// FSM state encodings and the layout of the packed summary record.
package window_sample_packer_pkg;

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] COLLECT = 1'b1;

   localparam int SLOT_W    = 5;
   localparam int COUNT_W   = 5;
   localparam int SUM_EXT_W = 5;

   // Record layout, LSB first: sum | max | count | first
   localparam int SUM_LSB = 0;

   function automatic int rec_width(input int data_w);
      return 3 * SLOT_W + 2 * data_w;
   endfunction

   function automatic int max_lsb(input int data_w);
      return data_w + SUM_EXT_W;
   endfunction

   function automatic int count_lsb(input int data_w);
      return 2 * data_w + SUM_EXT_W;
   endfunction

   function automatic int first_lsb(input int data_w);
      return 2 * data_w + SUM_EXT_W + COUNT_W;
   endfunction

   localparam int REC_W = rec_width(8);

endpackage

// File: rtl/window_sample_packer_rec_hold_reg.sv
// One-entry valid/ready holding register; a load is taken when the slot is empty or
// draining this cycle, otherwise it is refused and the held entry is kept.
module rec_hold_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_valid,
   input  logic [W-1:0] load_data,
   output logic         load_ok,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic room;

   assign room    = !out_valid || out_ready;
   assign load_ok = load_valid && room;

   always_ff @(posedge clk) begin
      // NOTE: the data register is reset as well, so a held record never outlives rst.
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load_ok) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/window_sample_packer.sv
// Collects samples inside each timer high window and emits one summary record
// (sum, count, max, first slot) per window, counting dropped records and aborted windows.
module window_sample_packer
   import window_sample_packer_pkg::*;
#(
   parameter int DATA_W           = 8,
   parameter int OUTPUT_UP_PERIOD = 16,
   parameter int EMIT_EMPTY       = 0,
   parameter int CNT_W            = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                win_high,
   input  logic [4:0]          slot,
   input  logic                low_start,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   output logic                rec_valid,
   input  logic                rec_ready,
   output logic [DATA_W+4:0]   rec_sum,
   output logic [4:0]          rec_count,
   output logic [DATA_W-1:0]   rec_max,
   output logic [4:0]          rec_first,
   output logic [CNT_W-1:0]    drop_cnt,
   output logic [CNT_W-1:0]    abort_cnt
);

   localparam int               SUM_W     = DATA_W + SUM_EXT_W;
   localparam int               RW        = rec_width(DATA_W);
   localparam logic [4:0]       LAST_SLOT = 5'(OUTPUT_UP_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [0:0]        state_q, state_n;
   logic [SUM_W-1:0]  sum_q, sum_n;
   logic [4:0]        count_q, count_n;
   logic [DATA_W-1:0] max_q, max_n;
   logic [4:0]        first_q, first_n;
   logic              start, finalize, abort, accept;
   logic              rec_load, rec_load_ok, rec_drop;
   logic [CNT_W-1:0]  drop_q, abort_q;
   logic [RW-1:0]     rec_word_in, rec_word_out;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_n  = state_q;
      start    = 1'b0;
      finalize = 1'b0;
      abort    = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_high && slot == '0) begin
               start   = 1'b1;
               state_n = COLLECT;
            end
         end
         COLLECT: begin
            if (low_start) begin
               finalize = 1'b1;
               state_n  = IDLE;
            end else if (!win_high) begin
               abort   = 1'b1;
               state_n = IDLE;
            end else if (slot == '0) begin
               // Timer wrapped without closing the window: count it and restart.
               abort = 1'b1;
               start = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign accept = win_high && in_valid && (slot <= LAST_SLOT)
                   && (start || state_q == COLLECT);

   // A start cycle begins from zero rather than adding to stale contents.
   always_comb begin
      sum_n   = start ? '0 : sum_q;
      count_n = start ? '0 : count_q;
      max_n   = start ? '0 : max_q;
      first_n = start ? '0 : first_q;
      if (accept) begin
         if (count_n == '0) first_n = slot;
         if (in_data > max_n) max_n = in_data;
         sum_n   = sum_n + SUM_W'(in_data);
         count_n = count_n + 5'd1;
      end
   end

   assign rec_load    = finalize && (count_n != '0 || EMIT_EMPTY != 0);
   assign rec_drop    = rec_load && !rec_load_ok;
   assign rec_word_in = {first_n, count_n, max_n, sum_n};

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         sum_q   <= '0;
         count_q <= '0;
         max_q   <= '0;
         first_q <= '0;
         drop_q  <= '0;
         abort_q <= '0;
      end else begin
         state_q <= state_n;
         if (state_n == COLLECT) begin
            sum_q   <= sum_n;
            count_q <= count_n;
            max_q   <= max_n;
            first_q <= first_n;
         end else begin
            sum_q   <= '0;
            count_q <= '0;
            max_q   <= '0;
            first_q <= '0;
         end
         if (rec_drop && drop_q != CNT_MAX) drop_q <= drop_q + CNT_ONE;
         if (abort && abort_q != CNT_MAX) abort_q <= abort_q + CNT_ONE;
      end
   end

   rec_hold_reg #(
      .W (RW)
   ) u_rec_hold (
      .clk        (clk),
      .rst        (rst),
      .load_valid (rec_load),
      .load_data  (rec_word_in),
      .load_ok    (rec_load_ok),
      .out_valid  (rec_valid),
      .out_ready  (rec_ready),
      .out_data   (rec_word_out)
   );

   assign rec_sum   = rec_word_out[SUM_LSB +: SUM_W];
   assign rec_max   = rec_word_out[max_lsb(DATA_W) +: DATA_W];
   assign rec_count = rec_word_out[count_lsb(DATA_W) +: COUNT_W];
   assign rec_first = rec_word_out[first_lsb(DATA_W) +: SLOT_W];
   assign drop_cnt  = drop_q;
   assign abort_cnt = abort_q;

endmodule

// File: tb/tb_window_sample_packer.sv
// Self-checking bench: a window-level timer model drives two packers (EMIT_EMPTY 0 and 1)
// and a scoreboard checks every accepted record.
module tb_window_sample_packer;

   typedef struct packed {
      logic [12:0] sum;
      logic [4:0]  count;
      logic [7:0]  max;
      logic [4:0]  first;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst, win_high, low_start, in_valid, rec_ready;
   logic [4:0] slot;
   logic [7:0] in_data;

   logic        rv0, rv1;
   logic [12:0] rs0, rs1;
   logic [4:0]  rc0, rc1, rf0, rf1;
   logic [7:0]  rm0, rm1;
   logic [7:0]  dc0, ac0;
   logic [1:0]  dc1, ac1;

   rec_t q0[$];
   rec_t q1[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic [7:0] smp[16];
   bit         sv[16];

   always #5 clk = ~clk;

   window_sample_packer #(.DATA_W(8), .OUTPUT_UP_PERIOD(16), .EMIT_EMPTY(0), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .win_high(win_high), .slot(slot), .low_start(low_start),
      .in_valid(in_valid), .in_data(in_data), .rec_valid(rv0), .rec_ready(rec_ready),
      .rec_sum(rs0), .rec_count(rc0), .rec_max(rm0), .rec_first(rf0),
      .drop_cnt(dc0), .abort_cnt(ac0));

   window_sample_packer #(.DATA_W(8), .OUTPUT_UP_PERIOD(16), .EMIT_EMPTY(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .win_high(win_high), .slot(slot), .low_start(low_start),
      .in_valid(in_valid), .in_data(in_data), .rec_valid(rv1), .rec_ready(rec_ready),
      .rec_sum(rs1), .rec_count(rc1), .rec_max(rm1), .rec_first(rf1),
      .drop_cnt(dc1), .abort_cnt(ac1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic sb_compare(input int which, input rec_t got);
      rec_t exp;
      bit   have;
      have = (which == 0) ? (q0.size() != 0) : (q1.size() != 0);
      check($sformatf("sb%0d_expected_record", which), 32'(have), 32'd1);
      if (have) begin
         exp = (which == 0) ? q0.pop_front() : q1.pop_front();
         check($sformatf("sb%0d_sum", which),   32'(got.sum),   32'(exp.sum));
         check($sformatf("sb%0d_count", which), 32'(got.count), 32'(exp.count));
         check($sformatf("sb%0d_max", which),   32'(got.max),   32'(exp.max));
         check($sformatf("sb%0d_first", which), 32'(got.first), 32'(exp.first));
      end
   endtask

   // Records are compared when the consumer takes them.
   always @(negedge clk) begin
      if (!rst && rec_ready) begin
         if (rv0) sb_compare(0, rec_t'{rs0, rc0, rm0, rf0});
         if (rv1) sb_compare(1, rec_t'{rs1, rc1, rm1, rf1});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pat();
      for (int i = 0; i < 16; i++) begin
         sv[i]  = 1'b0;
         smp[i] = 8'd0;
      end
   endtask

   task automatic put(input int s, input logic [7:0] v);
      sv[s]  = 1'b1;
      smp[s] = v;
   endtask

   // len==16 closes with low_start; shorter windows end by win_high falling (gap)
   // or by the next window restarting at slot 0 (no gap).
   task automatic run_window(input int len, input bit gap, input bit drop);
      rec_t e;
      e = '0;
      for (int s = 0; s < len; s++) begin
         win_high  = 1'b1;
         slot      = 5'(s);
         low_start = 1'b0;
         in_valid  = sv[s];
         in_data   = sv[s] ? smp[s] : 8'($urandom);
         if (sv[s]) begin
            if (e.count == 0) e.first = 5'(s);
            if (smp[s] > e.max) e.max = smp[s];
            e.sum   = e.sum + 13'(smp[s]);
            e.count = e.count + 5'd1;
         end
         tick();
      end
      win_high = 1'b0;
      in_valid = 1'b0;
      slot     = 5'd0;
      if (len == 16) begin
         low_start = 1'b1;
         if (!drop) begin
            if (e.count != 0) q0.push_back(e);
            q1.push_back(e);
         end
         tick();
         low_start = 1'b0;
      end
      if (gap) repeat (3) tick();
   endtask

   initial begin
      rst = 1'b1; win_high = 1'b0; low_start = 1'b0; in_valid = 1'b0;
      rec_ready = 1'b1; slot = 5'd0; in_data = 8'd0;
      clear_pat();
      repeat (3) tick();
      check("reset_rec_valid", 32'(rv0), 32'd0);
      check("reset_rec_sum", 32'(rs0), 32'd0);
      check("reset_rec_count", 32'(rc0), 32'd0);
      check("reset_rec_max", 32'(rm0), 32'd0);
      check("reset_rec_first", 32'(rf0), 32'd0);
      check("reset_drop_cnt", 32'(dc0), 32'd0);
      check("reset_abort_cnt", 32'(ac0), 32'd0);
      check("reset_rec_valid_e", 32'(rv1), 32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Full window: every slot carries slot+1.
      for (int i = 0; i < 16; i++) put(i, 8'(i + 1));
      run_window(16, 1'b0, 1'b0);
      check("full_valid_after_low_start", 32'(rv0), 32'd1);
      check("full_sum", 32'(rs0), 32'd136);
      tick();
      check("full_valid_one_cycle", 32'(rv0), 32'd0);
      repeat (2) tick();

      // Sparse window.
      clear_pat(); put(3, 8'd200); put(9, 8'd50);
      run_window(16, 1'b1, 1'b0);

      // Backpressure across two windows: second record is dropped.
      rec_ready = 1'b0;
      clear_pat(); put(1, 8'd10); put(2, 8'd20);
      run_window(16, 1'b1, 1'b0);
      check("bp_held_valid", 32'(rv0), 32'd1);
      clear_pat(); put(0, 8'd5);
      run_window(16, 1'b0, 1'b1);
      check("bp_drop_cnt", 32'(dc0), 32'd1);
      check("bp_drop_cnt_e", 32'(dc1), 32'd1);
      check("bp_stable_sum", 32'(rs0), 32'd30);
      check("bp_stable_count", 32'(rc0), 32'd2);
      check("bp_stable_max", 32'(rm0), 32'd20);
      check("bp_stable_first", 32'(rf0), 32'd1);
      rec_ready = 1'b1;
      tick();
      check("bp_valid_clears", 32'(rv0), 32'd0);
      repeat (2) tick();

      // Abort: win_high falls at slot 7 without low_start.
      clear_pat(); put(2, 8'd77);
      run_window(7, 1'b1, 1'b0);
      check("abort_cnt_1", 32'(ac0), 32'd1);
      check("abort_no_record", 32'(rv0), 32'd0);
      for (int i = 0; i < 16; i++) put(i, 8'(16 - i));
      run_window(16, 1'b1, 1'b0);

      // Empty window: only the EMIT_EMPTY instance produces a record.
      clear_pat();
      run_window(16, 1'b0, 1'b0);
      check("empty_no_record", 32'(rv0), 32'd0);
      check("empty_record_emitted_e", 32'(rv1), 32'd1);
      repeat (3) tick();

      // Timer wraps to slot 0 mid-window; second window restarts from its start cycle.
      for (int i = 0; i < 16; i++) put(i, 8'd99);
      run_window(6, 1'b0, 1'b0);
      clear_pat(); put(0, 8'd3); put(15, 8'd4);
      run_window(16, 1'b1, 1'b0);
      check("wrap_abort_cnt", 32'(ac0), 32'd2);

      // low_start while idle does nothing.
      low_start = 1'b1;
      tick();
      low_start = 1'b0;
      tick();
      check("idle_low_start_no_record", 32'(rv0), 32'd0);
      check("idle_low_start_abort_cnt", 32'(ac0), 32'd2);

      // Three more aborts: the 2-bit counter saturates at 3.
      clear_pat();
      repeat (3) run_window(3, 1'b1, 1'b0);
      check("abort_cnt_5", 32'(ac0), 32'd5);
      check("abort_cnt_saturates_e", 32'(ac1), 32'd3);

      // Reset at slot 10 with a record pending: everything clears.
      rec_ready = 1'b0;
      clear_pat(); put(5, 8'd42);
      run_window(16, 1'b1, 1'b0);
      clear_pat(); put(4, 8'd60);
      run_window(10, 1'b0, 1'b0);
      win_high = 1'b1; slot = 5'd10; in_valid = 1'b1; in_data = 8'd33; rst = 1'b1;
      tick();
      win_high = 1'b0; in_valid = 1'b0; slot = 5'd0;
      q0.delete();
      q1.delete();
      check("rst_mid_rec_valid", 32'(rv0), 32'd0);
      check("rst_mid_rec_sum", 32'(rs0), 32'd0);
      check("rst_mid_rec_max", 32'(rm0), 32'd0);
      check("rst_mid_drop_cnt", 32'(dc0), 32'd0);
      check("rst_mid_abort_cnt", 32'(ac0), 32'd0);
      check("rst_mid_rec_valid_e", 32'(rv1), 32'd0);
      rst = 1'b0;
      rec_ready = 1'b1;
      tick();
      clear_pat(); put(4, 8'd7);
      run_window(16, 1'b1, 1'b0);
      check("post_rst_abort_cnt", 32'(ac0), 32'd0);

      repeat (3) tick();
      check("sb0_drained", 32'(q0.size()), 32'd0);
      check("sb1_drained", 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
